// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: bundles the two handshakes of the FIFO read-side consumer.
//   FIFO side  : fifo_empty (in), fifo_d (in), fifo_r_en (out)
//   Stream side: m_valid (out), m_data (out), m_ready (in)
// Directions are given from the consumer's point of view on the master modport;
// the slave modport is the mirror used by whatever surrounds the consumer.
interface fifo_rd_stream_if #(
  parameter int DW = 16
);
  logic          fifo_empty;
  logic [DW-1:0] fifo_d;
  logic          fifo_r_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  modport master (
    input  fifo_empty, fifo_d, m_ready,
    output fifo_r_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_d, m_ready,
    input  fifo_r_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-domain consumer for the async FIFO. Drains the FIFO's
// r_en/D_out/empty interface and presents a valid/ready stream at one word per
// cycle. A 3-entry skid buffer covers the FIFO's one-cycle read latency so that
// fifo_r_en never depends combinationally on m_ready.
// Ports:
//   r_clk    : read-domain clock
//   rrst_n   : async active-low reset (shared with the FIFO read pointer)
//   bus      : fifo_rd_stream_if.master (fifo_empty/fifo_d/fifo_r_en,
//              m_valid/m_data/m_ready)
//   rd_count : words delivered downstream, wraps modulo 2^CNT_W
//   busy     : buffer non-empty or a read is in flight
module fifo_rd_stream #(
  parameter int DW        = 16,
  parameter int BUF_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic              r_clk,
  input  logic              rrst_n,
  fifo_rd_stream_if.master  bus,
  output logic [CNT_W-1:0]  rd_count,
  output logic              busy
);

  // Pointer/occupancy widths below are sized for exactly three entries.
  if (BUF_DEPTH != 3) begin : g_depth_chk
    $error("fifo_rd_stream: BUF_DEPTH must be 3");
  end

  logic                          r_pend;
  logic [1:0]                    r_occ;
  logic [1:0]                    r_head;
  logic [1:0]                    r_tail;
  logic [BUF_DEPTH-1:0][DW-1:0]  r_buf;
  logic [CNT_W-1:0]              r_cnt;

  logic [2:0] w_inflight;
  logic       w_rd_en;
  logic       w_valid;
  logic       w_push;
  logic       w_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for every issued read: occupancy plus the read in flight
  // must stay within the buffer, so no overflow is possible even if the
  // downstream stalls for ever. Only registered state and fifo_empty feed it.
  assign w_inflight = {1'b0, r_occ} + {2'b00, r_pend};
  assign w_rd_en    = !bus.fifo_empty && (w_inflight < 3'd3);

  assign w_valid = (r_occ != 2'd0);
  // The word requested last cycle is on fifo_d now; it is always captured.
  assign w_push  = r_pend;
  assign w_pop   = w_valid && bus.m_ready;

  assign bus.fifo_r_en = w_rd_en;
  assign bus.m_valid   = w_valid;
  assign bus.m_data    = r_buf[r_head];
  assign rd_count      = r_cnt;
  assign busy          = w_valid || r_pend;

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_pend <= 1'b0;
      r_occ  <= 2'd0;
      r_head <= 2'd0;
      r_tail <= 2'd0;
      r_buf  <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_rd_en;
      if (w_push) begin
        r_buf[r_tail] <= bus.fifo_d;
        r_tail        <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
        r_cnt  <= r_cnt + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
  localparam int DW    = 16;
  localparam int CNT_W = 16;

  logic             r_clk = 1'b0;
  logic             rrst_n = 1'b0;
  logic [CNT_W-1:0] rd_count;
  logic             busy;

  fifo_rd_stream_if #(.DW(DW)) bus();

  fifo_rd_stream #(.DW(DW), .BUF_DEPTH(3), .CNT_W(CNT_W)) dut (
    .r_clk    (r_clk),
    .rrst_n   (rrst_n),
    .bus      (bus),
    .rd_count (rd_count),
    .busy     (busy)
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    bit          rdy;
    bit          ren;
    bit          vld;
    bit          bsy;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[10];

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] fq[$];     // FIFO contents model
  logic [DW-1:0] exp_q[$];  // scoreboard: words expected downstream, in order
  int n_ren, n_vld, first_vld, last_vld, cyc, viol, stall_viol;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic clr_stats();
    n_ren = 0; n_vld = 0; first_vld = -1; last_vld = -1; cyc = 0;
  endtask

  // Starts and ends at a falling edge. Inputs are driven, outputs sampled
  // before the rising edge; the FIFO model answers a read after the edge.
  task automatic cycle(input bit rdy, input bit gap);
    logic ren;
    bus.m_ready    = rdy;
    bus.fifo_empty = (fq.size() == 0) || gap;
    #1;
    ren = bus.fifo_r_en;
    if (ren && bus.fifo_empty) viol++;
    if (ren) n_ren++;
    if (bus.m_valid) begin
      n_vld++;
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
    end
    if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data)) stall_viol++;
    prev_stall = bus.m_valid && !rdy;
    prev_data  = bus.m_data;
    if (bus.m_valid && rdy) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL extra_word: got %0h expected no word", bus.m_data);
      end else begin
        chk("sb_data", bus.m_data, exp_q.pop_front());
      end
    end
    @(posedge r_clk);
    #1;
    if (ren && fq.size() > 0) bus.fifo_d = fq.pop_front();
    cyc++;
    @(negedge r_clk);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    fq.delete();
    exp_q.delete();
    bus.fifo_empty = 1'b1;
    bus.m_ready    = 1'b0;
    bus.fifo_d     = '0;
    prev_stall     = 1'b0;
    @(negedge r_clk);
    @(negedge r_clk);
    rrst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 10; i++)
      vecs[i] = '{rdy: 1'b0, ren: (i < 3), vld: (i >= 2), bsy: (i >= 1), data: 16'h0000};

    viol = 0; stall_viol = 0; prev_stall = 1'b0; prev_data = '0;
    bus.fifo_empty = 1'b1; bus.m_ready = 1'b0; bus.fifo_d = '0;
    @(negedge r_clk);
    do_reset();

    // Reset state and idle
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", rd_count, 0);
    chk("rst_data", bus.m_data, 0);
    clr_stats();
    repeat (10) cycle(1'b1, 1'b0);
    chk("idle_ren_pulses", n_ren, 0);
    chk("idle_valid", bus.m_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_count", rd_count, 0);

    // Single word
    clr_stats();
    load(16'hA5A5);
    repeat (8) cycle(1'b1, 1'b0);
    chk("single_ren_pulses", n_ren, 1);
    chk("single_valid_cycles", n_vld, 1);
    chk("single_latency", first_vld, 2);
    chk("single_count", rd_count, 1);
    chk("single_sb_empty", exp_q.size(), 0);

    // Streaming
    do_reset();
    clr_stats();
    for (int i = 0; i < 32; i++) load(16'(i));
    repeat (40) cycle(1'b1, 1'b0);
    chk("stream_valid_cycles", n_vld, 32);
    chk("stream_first", first_vld, 2);
    chk("stream_no_bubble", last_vld - first_vld, 31);
    chk("stream_count", rd_count, 32);
    chk("stream_sb_empty", exp_q.size(), 0);

    // Backpressure: table of per-cycle expectations with m_ready low
    do_reset();
    clr_stats();
    for (int i = 0; i < 8; i++) load(16'(i));
    for (int i = 0; i < 10; i++) begin
      bus.m_ready    = vecs[i].rdy;
      bus.fifo_empty = (fq.size() == 0);
      #1;
      chk($sformatf("bp%0d_ren", i), bus.fifo_r_en, vecs[i].ren);
      chk($sformatf("bp%0d_valid", i), bus.m_valid, vecs[i].vld);
      chk($sformatf("bp%0d_busy", i), busy, vecs[i].bsy);
      if (vecs[i].vld) chk($sformatf("bp%0d_data", i), bus.m_data, vecs[i].data);
      cycle(vecs[i].rdy, 1'b0);
    end
    chk("bp_ren_pulses", n_ren, 3);
    repeat (15) cycle(1'b1, 1'b0);
    chk("bp_sb_empty", exp_q.size(), 0);
    chk("bp_count", rd_count, 8);

    // Random ready and random FIFO gaps
    do_reset();
    clr_stats();
    viol = 0; stall_viol = 0;
    for (int i = 0; i < 1000; i++) load(16'($urandom_range(0, 65535)));
    while (exp_q.size() > 0 && cyc < 20000)
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    repeat (4) cycle(1'b1, 1'b0);
    chk("rand_sb_left", exp_q.size(), 0);
    chk("rand_count", rd_count, 1000);
    chk("rand_ren_while_empty", viol, 0);
    chk("rand_stall_stable", stall_viol, 0);

    // Async reset with occ=2, pend=1
    do_reset();
    clr_stats();
    for (int i = 0; i < 6; i++) load(16'h0100 + 16'(i));
    repeat (3) cycle(1'b0, 1'b0);
    chk("pre_rst_valid", bus.m_valid, 1);
    chk("pre_rst_busy", busy, 1);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("async_valid", bus.m_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_count", rd_count, 0);
    fq.delete();
    exp_q.delete();
    prev_stall = 1'b0;
    bus.fifo_empty = 1'b1;
    @(negedge r_clk);
    rrst_n = 1'b1;
    clr_stats();
    load(16'h1234);
    repeat (10) cycle(1'b1, 1'b0);
    chk("post_rst_valid_cycles", n_vld, 1);
    chk("post_rst_sb_empty", exp_q.size(), 0);
    chk("post_rst_count", rd_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
